// File: rtl/inst_prefetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word requests and buffers
// in-order responses in a small queue. Optional response bypass: PREFETCH_BYPASS_EN.
module inst_prefetch_unit #(
  parameter int unsigned DEPTH           = 4,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [31:0]            imem_rdata,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  input  logic                   freeze,
  output logic                   inst_valid,
  output logic [31:0]            inst_out,
  output logic [31:0]            inst_pc,
  output logic [31:0]            inst_pc_plus8,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   fetch_pc_reg;
  logic          fetch_en_reg;
  logic [CW-1:0] outstanding_reg;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] drop_cnt_reg;
  logic [CW-1:0] count_reg;
  logic [AW-1:0] q_rd_ptr_reg;
  logic [AW-1:0] q_wr_ptr_reg;
  logic [AW-1:0] tag_rd_ptr_reg;
  logic [AW-1:0] tag_wr_ptr_reg;

  logic [31:0] q_inst_mem [DEPTH];
  logic [31:0] q_pc_mem   [DEPTH];
  logic [31:0] tag_mem    [DEPTH];

  logic [CW:0]  occupancy;
  logic         issue_fire;
  logic         rsp_drop;
  logic         rsp_keep;
  logic         q_empty;
  logic         q_push;
  logic         q_pop;
  logic         bypass_hit;
  logic [31:0]  q_head_inst;
  logic [31:0]  q_head_pc;
  logic [31:0]  tag_head_pc;
  logic         unused_rpc_bits;

  assign unused_rpc_bits = ^redirect_pc[1:0];

  // Outstanding requests reserve queue slots, so a kept response always fits.
  assign occupancy  = {1'b0, count_reg} + {1'b0, outstanding_reg};
  assign imem_req   = fetch_en_reg && !redirect
                   && (occupancy < (CW+1)'(DEPTH))
                   && (outstanding_reg < CW'(MAX_OUTSTANDING));
  assign imem_addr  = fetch_pc_reg;
  assign issue_fire = imem_req && imem_gnt;

  assign rsp_drop = imem_rvalid && (drop_cnt_reg != '0);
  assign rsp_keep = imem_rvalid && (drop_cnt_reg == '0);
  assign q_empty  = (count_reg == '0);

`ifdef PREFETCH_BYPASS_EN
  assign bypass_hit = fetch_en_reg && q_empty && rsp_keep && !redirect;
`else
  assign bypass_hit = 1'b0;
`endif

  // A bypassed word that is consumed immediately never enters the queue.
  assign q_push = rsp_keep && !redirect && !(bypass_hit && !freeze);
  assign q_pop  = !q_empty && !freeze && !redirect;

  assign outstanding_next = outstanding_reg + CW'(issue_fire) - CW'(imem_rvalid);

  assign q_head_inst = q_inst_mem[q_rd_ptr_reg];
  assign q_head_pc   = q_pc_mem[q_rd_ptr_reg];
  assign tag_head_pc = tag_mem[tag_rd_ptr_reg];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_reg    <= {RESET_PC[31:2], 2'b00};
      fetch_en_reg    <= 1'b0;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
      count_reg       <= '0;
      q_rd_ptr_reg    <= '0;
      q_wr_ptr_reg    <= '0;
      tag_rd_ptr_reg  <= '0;
      tag_wr_ptr_reg  <= '0;
    end else begin
      fetch_en_reg    <= 1'b1;
      outstanding_reg <= outstanding_next;
      if (redirect) begin
        // Everything still in flight after this edge belongs to the old stream.
        fetch_pc_reg   <= {redirect_pc[31:2], 2'b00};
        drop_cnt_reg   <= outstanding_next;
        count_reg      <= '0;
        q_rd_ptr_reg   <= '0;
        q_wr_ptr_reg   <= '0;
        tag_rd_ptr_reg <= '0;
        tag_wr_ptr_reg <= '0;
      end else begin
        if (issue_fire) begin
          fetch_pc_reg   <= fetch_pc_reg + 32'd4;
          tag_wr_ptr_reg <= tag_wr_ptr_reg + 1'b1;
        end
        if (rsp_drop) drop_cnt_reg <= drop_cnt_reg - 1'b1;
        if (rsp_keep) tag_rd_ptr_reg <= tag_rd_ptr_reg + 1'b1;
        if (q_push)   q_wr_ptr_reg   <= q_wr_ptr_reg + 1'b1;
        if (q_pop)    q_rd_ptr_reg   <= q_rd_ptr_reg + 1'b1;
        count_reg <= count_reg + CW'(q_push) - CW'(q_pop);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (issue_fire) tag_mem[tag_wr_ptr_reg] <= fetch_pc_reg;
    if (q_push) begin
      q_inst_mem[q_wr_ptr_reg] <= imem_rdata;
      q_pc_mem[q_wr_ptr_reg]   <= tag_head_pc;
    end
  end

  always_comb begin
    inst_valid = 1'b0;
    inst_out   = '0;
    inst_pc    = '0;
    if (!q_empty) begin
      inst_valid = 1'b1;
      inst_out   = q_head_inst;
      inst_pc    = q_head_pc;
    end else if (bypass_hit) begin
      inst_valid = 1'b1;
      inst_out   = imem_rdata;
      inst_pc    = tag_head_pc;
    end
  end

  assign inst_pc_plus8 = inst_pc + 32'd8;
  assign q_count       = count_reg;

  a_no_push_when_full: assert property (@(posedge clock) disable iff (!reset_n)
    !(rsp_keep && (count_reg == CW'(DEPTH))));

endmodule

// File: tb/tb_inst_prefetch_unit.sv
// Self-checking bench for inst_prefetch_unit: in-order memory model with random
// grant/latency and an instruction-stream reference model (expected next PC).
module tb_inst_prefetch_unit;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef PREFETCH_BYPASS_EN
  localparam int FIRST_VALID = 1;
`else
  localparam int FIRST_VALID = 2;
`endif

  logic          clock = 1'b0;
  logic          reset_n;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [31:0]   imem_rdata;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          freeze;
  logic          inst_valid;
  logic [31:0]   inst_out;
  logic [31:0]   inst_pc;
  logic [31:0]   inst_pc_plus8;
  logic [CW-1:0] q_count;

  inst_prefetch_unit #(
    .DEPTH(DEPTH), .RESET_PC(32'h0000_0000), .MAX_OUTSTANDING(4)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .freeze(freeze),
    .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc),
    .inst_pc_plus8(inst_pc_plus8), .q_count(q_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } rsp_t;

  rsp_t        pend[$];
  int          cyc;
  int          n_pass;
  int          n_total;
  int          gnt_pct;
  int          lat_min;
  int          lat_max;
  logic        ctl_freeze;
  logic        ctl_redirect;
  logic [31:0] ctl_rpc;
  logic [31:0] col_pc  [4];
  logic [31:0] col_out [4];
  int          col_n;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_9E17;
  endfunction

  // One clock: apply controls and memory response after the edge, then
  // record grants/responses at the falling edge where tests observe.
  task automatic tick();
    rsp_t r;
    @(posedge clock);
    #1;
    cyc++;
    freeze      = ctl_freeze;
    redirect    = ctl_redirect;
    redirect_pc = ctl_rpc;
    imem_gnt    = reset_n && ($urandom_range(99) < gnt_pct);
    if (reset_n && pend.size() > 0 && pend[0].ready <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    @(negedge clock);
    if (!reset_n) begin
      pend.delete();
    end else begin
      if (imem_rvalid) void'(pend.pop_front());
      if (imem_req && imem_gnt) begin
        r.addr  = imem_addr;
        r.ready = cyc + $urandom_range(lat_max, lat_min);
        pend.push_back(r);
      end
    end
  endtask

  task automatic begin_reset();
    reset_n      = 1'b0;
    imem_gnt     = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = '0;
    ctl_freeze   = 1'b0;
    ctl_redirect = 1'b0;
    ctl_rpc      = '0;
    pend.delete();
    repeat (2) tick();
  endtask

  task automatic end_reset();
    reset_n = 1'b1;
    cyc     = -1;
  endtask

  // Gathers up to n consumed instructions (no comparisons).
  task automatic collect(input int n, input int budget);
    col_n = 0;
    for (int i = 0; i < budget && col_n < n; i++) begin
      tick();
      if (inst_valid && !freeze && !redirect) begin
        col_pc[col_n]  = inst_pc;
        col_out[col_n] = inst_out;
        col_n++;
      end
    end
  endtask

  task automatic test_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    begin_reset();
    n_total++; if (imem_req !== 1'b0) $display("FAIL reset_imem_req got %b want 0", imem_req); else n_pass++;
    n_total++; if (inst_valid !== 1'b0) $display("FAIL reset_inst_valid got %b want 0", inst_valid); else n_pass++;
    n_total++; if (inst_out !== 32'h0) $display("FAIL reset_inst_out got %h want 0", inst_out); else n_pass++;
    n_total++; if (inst_pc !== 32'h0) $display("FAIL reset_inst_pc got %h want 0", inst_pc); else n_pass++;
    n_total++; if (q_count !== '0) $display("FAIL reset_q_count got %0d want 0", q_count); else n_pass++;
    end_reset();
  endtask

  task automatic test_startup_latency();
    logic        exp_v;
    logic [31:0] exp_pc;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    begin_reset();
    end_reset();
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_v  = (k >= FIRST_VALID);
      exp_pc = 32'(4 * (k - FIRST_VALID));
      n_total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k))
        $display("FAIL startup_addr cyc %0d got req=%b addr=%h want req=1 addr=%h", k, imem_req, imem_addr, 32'(4 * k));
      else n_pass++;
      n_total++;
      if (inst_valid !== exp_v) $display("FAIL startup_valid cyc %0d got %b want %b", k, inst_valid, exp_v);
      else n_pass++;
      if (exp_v) begin
        n_total++;
        if (inst_pc !== exp_pc || inst_out !== mem_word(exp_pc) || inst_pc_plus8 !== exp_pc + 32'd8)
          $display("FAIL startup_inst cyc %0d got pc=%h out=%h pc8=%h want pc=%h out=%h pc8=%h",
                   k, inst_pc, inst_out, inst_pc_plus8, exp_pc, mem_word(exp_pc), exp_pc + 32'd8);
        else n_pass++;
      end
    end
  endtask

  task automatic test_freeze_fill();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    begin_reset();
    end_reset();
    ctl_freeze = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (inst_valid) begin
        n_total++;
        if (inst_pc !== 32'h0 || inst_out !== mem_word(32'h0))
          $display("FAIL freeze_hold cyc %0d got pc=%h out=%h want pc=0 out=%h", k, inst_pc, inst_out, mem_word(32'h0));
        else n_pass++;
      end
    end
    tick();
    n_total++; if (q_count !== CW'(4)) $display("FAIL freeze_q_full got %0d want 4", q_count); else n_pass++;
    n_total++; if (imem_req !== 1'b0) $display("FAIL freeze_req_drop got %b want 0", imem_req); else n_pass++;
    n_total++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0) $display("FAIL freeze_head got v=%b pc=%h want v=1 pc=0", inst_valid, inst_pc);
    else n_pass++;
    ctl_freeze = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * i) || inst_out !== mem_word(32'(4 * i)))
        $display("FAIL freeze_drain %0d got v=%b pc=%h out=%h want v=1 pc=%h out=%h",
                 i, inst_valid, inst_pc, inst_out, 32'(4 * i), mem_word(32'(4 * i)));
      else n_pass++;
    end
  endtask

  task automatic test_redirect_drop();
    gnt_pct = 100; lat_min = 4; lat_max = 4;
    begin_reset();
    end_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k))
        $display("FAIL drop_issue %0d got req=%b addr=%h want req=1 addr=%h", k, imem_req, imem_addr, 32'(4 * k));
      else n_pass++;
    end
    ctl_redirect = 1'b1; ctl_rpc = 32'h100;
    tick();
    n_total++; if (imem_req !== 1'b0) $display("FAIL drop_no_req_in_redirect got %b want 0", imem_req); else n_pass++;
    ctl_redirect = 1'b0;
    tick();
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100)
      $display("FAIL drop_new_addr got req=%b addr=%h want req=1 addr=00000100", imem_req, imem_addr);
    else n_pass++;
    collect(3, 40);
    n_total++;
    if (col_n != 3) $display("FAIL drop_timeout got %0d instructions want 3", col_n);
    else n_pass++;
    for (int i = 0; i < col_n; i++) begin
      n_total++;
      if (col_pc[i] !== 32'h100 + 32'(4 * i) || col_out[i] !== mem_word(32'h100 + 32'(4 * i)))
        $display("FAIL drop_stream %0d got pc=%h out=%h want pc=%h", i, col_pc[i], col_out[i], 32'h100 + 32'(4 * i));
      else n_pass++;
    end
  endtask

  task automatic test_redirect_unaligned();
    gnt_pct = 100; lat_min = 1; lat_max = 3;
    ctl_redirect = 1'b1; ctl_rpc = 32'h203;
    tick();
    ctl_redirect = 1'b0;
    tick();
    n_total++;
    if (imem_addr !== 32'h200) $display("FAIL unaligned_addr got %h want 00000200", imem_addr); else n_pass++;
    collect(1, 30);
    n_total++;
    if (col_n != 1 || col_pc[0] !== 32'h200 || col_out[0] !== mem_word(32'h200))
      $display("FAIL unaligned_inst got n=%0d pc=%h want pc=00000200", col_n, col_pc[0]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    gnt_pct = 100; lat_min = 1; lat_max = 2;
    ctl_redirect = 1'b1; ctl_rpc = 32'h40;
    tick();
    ctl_rpc = 32'h80;
    tick();
    ctl_redirect = 1'b0;
    tick();
    n_total++;
    if (imem_addr !== 32'h80) $display("FAIL b2b_addr got %h want 00000080", imem_addr); else n_pass++;
    collect(2, 30);
    n_total++;
    if (col_n != 2 || col_pc[0] !== 32'h80 || col_pc[1] !== 32'h84)
      $display("FAIL b2b_stream got n=%0d pc0=%h pc1=%h want 00000080 00000084", col_n, col_pc[0], col_pc[1]);
    else n_pass++;
  endtask

  task automatic test_pc_wrap();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    ctl_redirect = 1'b1; ctl_rpc = 32'hFFFF_FFFC;
    tick();
    ctl_redirect = 1'b0;
    tick();
    n_total++;
    if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr0 got %h want fffffffc", imem_addr); else n_pass++;
    tick();
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL wrap_addr1 got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
    else n_pass++;
    for (int i = 0; i < 10 && !inst_valid; i++) tick();
    n_total++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst_pc_plus8 !== 32'h4)
      $display("FAIL wrap_plus8 got v=%b pc=%h pc8=%h want v=1 pc=fffffffc pc8=00000004", inst_valid, inst_pc, inst_pc_plus8);
    else n_pass++;
    collect(1, 10);
    n_total++;
    if (col_n != 1 || col_pc[0] !== 32'h0) $display("FAIL wrap_next got n=%0d pc=%h want 00000000", col_n, col_pc[0]);
    else n_pass++;
  endtask

  task automatic test_reset_midop();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    ctl_freeze = 1'b1;
    repeat (5) tick();
    #2;
    reset_n     = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    n_total++;
    if (inst_valid !== 1'b0 || q_count !== '0 || imem_req !== 1'b0 || inst_pc !== 32'h0)
      $display("FAIL midop_reset got v=%b q=%0d req=%b pc=%h want all 0", inst_valid, q_count, imem_req, inst_pc);
    else n_pass++;
    begin_reset();
    end_reset();
    tick();
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL midop_restart got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic        prev_hold;
    logic [31:0] prev_pc;
    logic [31:0] prev_out;
    int          consumed;
    gnt_pct = 70; lat_min = 1; lat_max = 3;
    begin_reset();
    end_reset();
    exp_pc = 32'h0; prev_hold = 1'b0; prev_pc = '0; prev_out = '0; consumed = 0;
    for (int k = 0; k < 1500; k++) begin
      ctl_freeze   = ($urandom_range(99) < 30);
      ctl_redirect = ($urandom_range(99) < 4);
      ctl_rpc      = $urandom;
      tick();
      if (redirect) begin
        n_total++;
        if (imem_req !== 1'b0) $display("FAIL rnd_req_in_redirect cyc %0d got %b want 0", k, imem_req); else n_pass++;
      end
      if (imem_req) begin
        n_total++;
        if (imem_addr[1:0] !== 2'b00) $display("FAIL rnd_addr_align cyc %0d got %h", k, imem_addr); else n_pass++;
      end
      n_total++;
      if (q_count > CW'(DEPTH)) $display("FAIL rnd_q_bound cyc %0d got %0d want <=%0d", k, q_count, DEPTH); else n_pass++;
      if (prev_hold) begin
        n_total++;
        if (inst_valid !== 1'b1 || inst_pc !== prev_pc || inst_out !== prev_out)
          $display("FAIL rnd_freeze_hold cyc %0d got v=%b pc=%h out=%h want v=1 pc=%h out=%h",
                   k, inst_valid, inst_pc, inst_out, prev_pc, prev_out);
        else n_pass++;
      end
      if (inst_valid && !freeze && !redirect) begin
        n_total++;
        if (inst_pc !== exp_pc || inst_out !== mem_word(exp_pc) || inst_pc_plus8 !== exp_pc + 32'd8)
          $display("FAIL rnd_stream cyc %0d got pc=%h out=%h pc8=%h want pc=%h out=%h pc8=%h",
                   k, inst_pc, inst_out, inst_pc_plus8, exp_pc, mem_word(exp_pc), exp_pc + 32'd8);
        else n_pass++;
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      prev_hold = inst_valid && freeze && !redirect;
      prev_pc   = inst_pc;
      prev_out  = inst_out;
      if (redirect) exp_pc = {redirect_pc[31:2], 2'b00};
    end
    n_total++;
    if (consumed < 100) $display("FAIL rnd_progress got %0d instructions want >=100", consumed); else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0; cyc = 0;
    reset_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; freeze = 1'b0;
    ctl_freeze = 1'b0; ctl_redirect = 1'b0; ctl_rpc = '0;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    test_reset();
    test_startup_latency();
    test_freeze_fill();
    test_redirect_drop();
    test_redirect_unaligned();
    test_back_to_back();
    test_pc_wrap();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/inst_prefetch_unit.md
Name: inst_prefetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction register pipeline stage and the ID stage.
- Owns the fetch PC and issues word requests to instruction memory.
- Buffers returned words in a small in-order prefetch queue.
- Presents one instruction per cycle, holds under pipeline freeze, and flushes on branch redirect.

Parameters:
- DEPTH, 4, prefetch queue entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- MAX_OUTSTANDING, 4, maximum imem requests in flight; must be ≤ DEPTH.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- imem_req  out  1  request valid to instruction memory.
- imem_addr  out  32  word-aligned fetch address; bits [1:0] are always 0.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid; responses return in order, at least 1 cycle after grant.
- imem_rdata  in  32  returned instruction word.
- redirect  in  1  branch/PC-write flush from the execute or writeback stage.
- redirect_pc  in  32  new fetch target; bits [1:0] are ignored (forced to 0).
- freeze  in  1  downstream freeze (forwarding/load stall); the held instruction is not consumed.
- inst_valid  out  1  inst_out/inst_pc are meaningful.
- inst_out  out  32  instruction word to the instruction register stage.
- inst_pc  out  32  address of inst_out.
- inst_pc_plus8  out  32  inst_pc + 8 (architectural PC read value).
- q_count  out  $clog2(DEPTH)+1  current queue occupancy.

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc = RESET_PC; queue empty; outstanding = 0; drop_cnt = 0.
  - imem_req = 0, inst_valid = 0, inst_out = 0, inst_pc = 0, q_count = 0.
- Issue rule:
  - imem_req = 1 when (q_count + outstanding) < DEPTH, outstanding < MAX_OUTSTANDING, and redirect is low.
  - imem_addr = fetch_pc.
  - On imem_req & imem_gnt: fetch_pc += 4 (wraps mod 2^32) and outstanding increments.
  - Each request's PC is pushed to an internal in-order tag FIFO.
- Response:
  - On imem_rvalid: outstanding decrements.
  - If drop_cnt > 0: drop_cnt decrements and the word is discarded.
  - Otherwise {imem_rdata, tagged PC} is pushed into the queue.
  - A response arriving with a full queue is impossible by construction; an assertion checks for it.
- Output:
  - inst_valid = queue non-empty; inst_out/inst_pc are the head entry.
  - Pop when inst_valid & ~freeze.
  - While freeze is high, the outputs are held stable.
  - Push and pop in the same cycle leave q_count unchanged.
- Redirect, taking priority over everything in the same cycle:
  - Queue cleared; a same-cycle pop and push are both ignored; inst_valid = 0 next cycle.
  - fetch_pc = {redirect_pc[31:2], 2'b00}; no request is issued in the redirect cycle.
  - drop_cnt = outstanding + (grant this cycle ? 1 : 0) − (non-dropped-or-dropped rvalid this cycle ? 1 : 0), i.e. all in-flight responses are discarded.
  - Tag FIFO is flushed consistently.
  - The first instruction from the new target appears at least 2 cycles after redirect (grant + 1-cycle memory).
- Back-to-back redirects: the last one wins; drop_cnt accumulates correctly.
- Reset mid-operation: all state returns to reset values immediately; stale responses after reset release are not expected (memory is reset together with the fetch stage).
- Latency: with no bypass, an empty queue, and 1-cycle memory, the request cycle is N and inst_valid rises at N+2.

Optional Feature:
- Macro: PREFETCH_BYPASS_EN.
- Defined: when the queue is empty, a non-dropped response arrives, and there is no redirect, the word drives inst_out/inst_pc combinationally with inst_valid = 1 in the response cycle.
  - If ~freeze, it is consumed and not enqueued.
  - If freeze, it is enqueued normally.
  - Empty-queue latency drops by one cycle.
- Undefined: all responses go through the queue; outputs are purely registered.

Test Plan:
- Reset then release with 1-cycle memory, freeze = 0 → imem_addr sequence 0x0, 0x4, 0x8…; inst_pc 0x0 with inst_valid at cycle 2 (cycle 1 with PREFETCH_BYPASS_EN); inst_pc_plus8 = 0x8.
- freeze held high for 6 cycles → queue fills to 4, imem_req drops to 0, inst_out and inst_pc stay at 0x0; on release, PCs 0x0, 0x4, 0x8, 0xC are consumed in order with no loss or duplicate.
- redirect to 0x100 while 3 requests are outstanding → 3 responses discarded; next inst_pc = 0x100; no instruction from the old stream is delivered.
- redirect_pc = 0x203 → imem_addr = 0x200; inst_pc = 0x200.
- redirect to 0x40 then 0x80 on consecutive cycles → first delivered inst_pc = 0x80.
- fetch_pc = 0xFFFF_FFFC → next imem_addr = 0x0; inst_pc_plus8 for 0xFFFF_FFFC = 0x4.
